tile_lane_judge: RTL and testbench
==================================

// Module: tile_lane_judge
// PURPOSE
//  Consumer end of the tile generator. Holds a DEPTH-row falling-tile playfield and
//  pulls one new 4-bit row from the generator per scroll tick. Judges player key
//  presses against the bottom row and keeps the score. Runs the IDLE/PLAY/OVER game
//  FSM. Sits between the random tile source, the debounced key inputs and the renderer.
// PARAMETERS
//  DEPTH    4   visible rows in playfield (>=2); row 0 = bottom (hit row)
//  SCORE_W  10  score width; score saturates at 2**SCORE_W-1
//  LIVES    3   starting lives (1..3), used only when STRIKE_LIVES_EN is defined
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          reset, synchronous, active-low
//  start        in   1          1-cycle pulse: begin/restart a game
//  scroll_tick  in   1          1-cycle pulse: advance playfield one row
//  new_row      in   4          next row from generator (bit i = lane i tile)
//  keys         in   4          debounced lane keys, level, 1 = pressed
//  row_take     out  1          1-cycle pulse: new_row consumed this cycle (combinational)
//  rows         out  4*DEPTH    pending tiles; rows[4k+3:4k] = row k
//  score        out  SCORE_W    tiles hit this game
//  state        out  2          0=IDLE 1=PLAY 2=OVER
//  hit          out  1          registered pulse: >=1 tile cleared last cycle
//  miss         out  1          registered pulse: miss event last cycle
//  lives        out  2          lives remaining
// BEHAVIOUR
//  Reset: state=IDLE, rows=0, score=0, hit=miss=0, keys_q=0, lives=LIVES (macro) or 0.
//  press = keys & ~keys_q (rising edge per lane); keys_q updated every cycle.
//  IDLE/OVER: start -> rows=0, score=0, lives=LIVES, state=PLAY next cycle.
//   keys and scroll_tick are ignored.
//  PLAY: start ignored. Per cycle, evaluate in this order against current row 0 (b):
//   1. if press!=0: wrong = press & ~b. If wrong!=0 -> miss event; no bits cleared.
//      Else b' = b & ~press, score += popcount(press) (saturating), hit=1 next cycle.
//   2. if scroll_tick: if b' (after step 1) != 0 -> miss event (missed tile);
//      else shift: row k <= row k+1, row DEPTH-1 <= new_row, row_take=1.
//   An empty bottom row (0000) requires no press; any press on it is wrong.
//  Miss event without macro: state=OVER next cycle, rows frozen, no shift, row_take=0.
//  Step 1 miss takes priority: a scroll in the same cycle does not shift.
//  hit/miss are asserted exactly 1 cycle after the event cycle, for 1 cycle.
//  row_take is asserted only in PLAY, in the same cycle as the scroll_tick it serves.
//  Reset mid-game: reset dominates every input and returns to reset values.
//  Score at max: stays at max; hit is still pulsed.
// CONFIGURATION
//  STRIKE_LIVES_EN defined: a miss event decrements lives.
//   If lives was 1 -> lives=0, state=OVER. Otherwise state stays PLAY.
//   Wrong press: no bits cleared.
//   Missed tile on scroll: the row is discarded and the shift proceeds (row_take=1).
//   At most one life is lost per cycle.
//  STRIKE_LIVES_EN undefined: lives tied to 0; the first miss ends the game.
// TESTING
//  1. reset, start, 4 ticks with new_row=1,2,4,8 -> rows=0x8421, row_take x4, score=0.
//  2. bottom=0101, press lanes 0,2 same cycle -> next: bottom=0000, score+=2, hit=1.
//  3. bottom=0001, press lane 1 -> miss=1, state=OVER; later start -> PLAY, score=0.
//  4. bottom=0010, press lane1 and scroll_tick same cycle -> shift, no miss, score+1.
//  5. bottom=0011, scroll_tick, no press -> macro off: OVER, rows unchanged;
//     macro on, LIVES=3: lives=2, shift happens, state=PLAY.
//  6. score preloaded to 1023 (SCORE_W=10), hit -> score stays 1023, hit=1.

Source files
------------

// File: rtl/tile_lane_judge.sv
// tile_lane_judge: consumer end of the tile generator.
// Holds a DEPTH-row falling-tile playfield, pulls one new 4-bit row per scroll
// tick, judges lane key presses against the bottom row (row 0), keeps a
// saturating score and runs the IDLE/PLAY/OVER game FSM.
// Optional feature macro: STRIKE_LIVES_EN -- when defined, each miss event costs
// one life and the game only ends when the last life is lost; when undefined,
// lives reads as 0 and the first miss ends the game.
module tile_lane_judge #(
  parameter int DEPTH   = 4,
  parameter int SCORE_W = 10,
  parameter int LIVES   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 scroll_tick,
  input  logic [3:0]           new_row,
  input  logic [3:0]           keys,
  output logic                 row_take,
  output logic [4*DEPTH-1:0]   rows,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           state,
  output logic                 hit,
  output logic                 miss,
  output logic [1:0]           lives
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  // Parameter sanity: these blocks elaborate to nothing for legal settings
  // and exist so an illegal DEPTH/LIVES is easy to spot in the hierarchy.
  if (DEPTH < 2) begin : g_depth_too_small
  end
  if (LIVES < 1 || LIVES > 3) begin : g_lives_out_of_range
  end

  logic [1:0]         state_reg, state_next;
  logic [4*DEPTH-1:0] rows_reg, rows_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic               hit_reg, hit_next;
  logic               miss_reg, miss_next;
  logic [3:0]         keys_q_reg;

  logic [3:0]         press, wrong, bottom, bottom_after;
  logic               in_play, press_any, press_miss, press_hit;
  logic               tile_miss, miss_event, shift_en;
  logic [4*DEPTH-1:0] rows_shifted;
  logic [2:0]         press_cnt;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;

  // Judging: rising-edge presses are checked against the bottom row first,
  // then a scroll tick either shifts the field or reports an uncleared tile.
  assign press        = keys & ~keys_q_reg;
  assign in_play      = (state_reg == S_PLAY);
  assign bottom       = rows_reg[3:0];
  assign wrong        = press & ~bottom;
  assign press_any    = |press;
  assign press_miss   = in_play && press_any && (|wrong);
  assign press_hit    = in_play && press_any && !(|wrong);
  assign bottom_after = press_hit ? (bottom & ~press) : bottom;
  assign tile_miss    = in_play && scroll_tick && !press_miss && (|bottom_after);
  assign miss_event   = press_miss || tile_miss;

`ifdef STRIKE_LIVES_EN
  // A missed tile is discarded and the field still scrolls.
  assign shift_en = in_play && scroll_tick && !press_miss;
`else
  // Any miss freezes the field for the game-over screen.
  assign shift_en = in_play && scroll_tick && !press_miss && !tile_miss;
`endif

  assign row_take = shift_en;

  assign press_cnt = 3'(press[0]) + 3'(press[1]) + 3'(press[2]) + 3'(press[3]);
  assign score_sum = {1'b0, score_reg} + (SCORE_W+1)'(press_cnt);
  assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // Playfield shift: every row drops by one, the generator row enters at the top.
  for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_shift
    assign rows_shifted[4*gi +: 4] = rows_reg[4*(gi+1) +: 4];
  end
  assign rows_shifted[4*(DEPTH-1) +: 4] = new_row;

`ifdef STRIKE_LIVES_EN
  logic [1:0] lives_reg, lives_next;
  assign lives = lives_reg;
`else
  assign lives = 2'd0;
`endif

  // Next-state logic for the game FSM, playfield, score and event pulses.
  always_comb begin
    state_next = state_reg;
    rows_next  = rows_reg;
    score_next = score_reg;
    hit_next   = 1'b0;
    miss_next  = 1'b0;
`ifdef STRIKE_LIVES_EN
    lives_next = lives_reg;
`endif
    if (!in_play) begin
      if (start) begin
        state_next = S_PLAY;
        rows_next  = '0;
        score_next = '0;
`ifdef STRIKE_LIVES_EN
        lives_next = 2'(LIVES);
`endif
      end
    end else begin
      hit_next  = press_hit;
      miss_next = miss_event;
      if (press_hit)
        score_next = score_sat;
      if (shift_en)
        rows_next = rows_shifted;
      else if (press_hit && !tile_miss)
        rows_next[3:0] = bottom_after;
      if (miss_event) begin
`ifdef STRIKE_LIVES_EN
        if (lives_reg <= 2'd1) begin
          lives_next = 2'd0;
          state_next = S_OVER;
        end else begin
          lives_next = lives_reg - 2'd1;
        end
`else
        state_next = S_OVER;
`endif
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      rows_reg   <= '0;
      score_reg  <= '0;
      hit_reg    <= 1'b0;
      miss_reg   <= 1'b0;
      keys_q_reg <= 4'd0;
`ifdef STRIKE_LIVES_EN
      lives_reg  <= 2'(LIVES);
`endif
    end else begin
      state_reg  <= state_next;
      rows_reg   <= rows_next;
      score_reg  <= score_next;
      hit_reg    <= hit_next;
      miss_reg   <= miss_next;
      keys_q_reg <= keys;
`ifdef STRIKE_LIVES_EN
      lives_reg  <= lives_next;
`endif
    end
  end

  assign state = state_reg;
  assign rows  = rows_reg;
  assign score = score_reg;
  assign hit   = hit_reg;
  assign miss  = miss_reg;

endmodule

// File: tb/tb_tile_lane_judge.sv
// tb_tile_lane_judge: directed-vector bench for tile_lane_judge (DEPTH=4,
// SCORE_W=10, LIVES=3). Expected values are hand-computed in the stimulus.
// Works with STRIKE_LIVES_EN defined or undefined.
module tb_tile_lane_judge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        scroll_tick = 1'b0;
  logic [3:0]  new_row = 4'd0;
  logic [3:0]  keys = 4'd0;
  logic        row_take;
  logic [15:0] rows;
  logic [9:0]  score;
  logic [1:0]  state;
  logic        hit;
  logic        miss;
  logic [1:0]  lives;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef STRIKE_LIVES_EN
  localparam logic [1:0] LIVES_RST = 2'd3;
`else
  localparam logic [1:0] LIVES_RST = 2'd0;
`endif

  tile_lane_judge #(.DEPTH(4), .SCORE_W(10), .LIVES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scroll_tick(scroll_tick),
    .new_row(new_row), .keys(keys), .row_take(row_take), .rows(rows),
    .score(score), .state(state), .hit(hit), .miss(miss), .lives(lives)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check combinational row_take, then
  // let the edge happen and return #1 after it for registered checks.
  task automatic cyc(input logic st, input logic tk, input logic [3:0] nr,
                     input logic [3:0] ky, input logic exp_rt);
    @(negedge clk);
    start = st; scroll_tick = tk; new_row = nr; keys = ky;
    #1 check_eq("row_take", {31'd0, row_take}, {31'd0, exp_rt});
    @(posedge clk);
    #1;
    start = 1'b0; scroll_tick = 1'b0;
    $display("[TB] txn st=%0b tk=%0b nr=%h ky=%h -> state=%0d rows=%h score=%0d hit=%0b miss=%0b lives=%0d",
             st, tk, nr, ky, state, rows, score, hit, miss, lives);
  endtask

  task automatic check_regs(input string tag, input logic [1:0] e_state,
                            input logic [15:0] e_rows, input logic [9:0] e_score,
                            input logic e_hit, input logic e_miss);
    check_eq({tag, ".state"}, {30'd0, state}, {30'd0, e_state});
    check_eq({tag, ".rows"},  {16'd0, rows},  {16'd0, e_rows});
    check_eq({tag, ".score"}, {22'd0, score}, {22'd0, e_score});
    check_eq({tag, ".hit"},   {31'd0, hit},   {31'd0, e_hit});
    check_eq({tag, ".miss"},  {31'd0, miss},  {31'd0, e_miss});
  endtask

  // Reset with hostile inputs active to show reset dominates them.
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; scroll_tick = 1'b1; new_row = 4'hF; keys = 4'hF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; scroll_tick = 1'b0; keys = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_regs("reset", 2'd0, 16'h0000, 10'd0, 1'b0, 1'b0);
    check_eq("reset.lives", {30'd0, lives}, {30'd0, LIVES_RST});
    $display("[TB] txn reset -> state=%0d rows=%h score=%0d", state, rows, score);
  endtask

  initial begin
    do_reset();

    // 1: start, then four ticks loading 1,2,4,8.
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    check_regs("t1.start", 2'd1, 16'h0000, 10'd0, 1'b0, 1'b0);
    check_eq("t1.lives", {30'd0, lives}, {30'd0, LIVES_RST});
    cyc(1'b0, 1'b1, 4'h1, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h2, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h4, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h8, 4'h0, 1'b1);
    check_regs("t1.fill", 2'd1, 16'h8421, 10'd0, 1'b0, 1'b0);

    // Walk the field down to a 0101 bottom row.
    cyc(1'b0, 1'b0, 4'h0, 4'h1, 1'b0);
    check_regs("clr_l0", 2'd1, 16'h8420, 10'd1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'h5, 4'h0, 1'b1);
    check_regs("shift5", 2'd1, 16'h5842, 10'd1, 1'b0, 1'b0);
    // 4: bottom 0010, press lane1 with scroll in same cycle.
    cyc(1'b0, 1'b1, 4'h0, 4'h2, 1'b1);
    check_regs("t4.press_scroll", 2'd1, 16'h0584, 10'd2, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'h4, 1'b0);
    check_regs("clr_l2", 2'd1, 16'h0580, 10'd3, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h3, 4'h8, 1'b1);
    check_regs("clr_l3_shift", 2'd1, 16'h3005, 10'd4, 1'b1, 1'b0);

    // 2: bottom 0101, press lanes 0 and 2 together.
    cyc(1'b0, 1'b0, 4'h0, 4'h5, 1'b0);
    check_regs("t2.double", 2'd1, 16'h3000, 10'd6, 1'b1, 1'b0);

    // Build a 0011 bottom row.
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h1, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    check_regs("pre_t5", 2'd1, 16'h0103, 10'd6, 1'b0, 1'b0);

    // 5: scroll over an uncleared 0011 row.
`ifdef STRIKE_LIVES_EN
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    check_regs("t5.strike", 2'd1, 16'h0010, 10'd6, 1'b0, 1'b1);
    check_eq("t5.lives", {30'd0, lives}, 32'd2);
`else
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
    check_regs("t5.over", 2'd2, 16'h0103, 10'd6, 1'b0, 1'b1);
`endif
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    check_eq("t5.miss_one_cycle", {31'd0, miss}, 32'd0);

    // Reset mid-game, then 3: wrong press on a 0001 bottom row.
    do_reset();
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'h3, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    check_regs("t3.fill", 2'd1, 16'h0003, 10'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'h2, 1'b0);
    check_regs("t3.clr_l1", 2'd1, 16'h0001, 10'd1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'h2, 1'b0);
`ifdef STRIKE_LIVES_EN
    check_regs("t3.wrong", 2'd1, 16'h0001, 10'd1, 1'b0, 1'b1);
    check_eq("t3.lives", {30'd0, lives}, 32'd2);
    do_reset();
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
`else
    check_regs("t3.wrong", 2'd2, 16'h0001, 10'd1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'h7, 4'h0, 1'b0);
    check_regs("t3.over_frozen", 2'd2, 16'h0001, 10'd1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
`endif
    check_regs("t3.restart", 2'd1, 16'h0000, 10'd0, 1'b0, 1'b0);

    // 6: score saturation. Fill with 1111 rows, clear 4 tiles per round.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    check_regs("t6.fill", 2'd1, 16'hFFFF, 10'd0, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      cyc(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
      cyc(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    end
    check_regs("t6.pre_sat", 2'd1, 16'hFFFF, 10'd1020, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
    check_regs("t6.sat", 2'd1, 16'hFFF0, 10'd1023, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
    check_regs("t6.hold_max", 2'd1, 16'hFFF0, 10'd1023, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
